simpsons_door_arbiter: RTL and testbench
========================================

# simpsons_door_arbiter

Door-access controller that sits in front of `simpsons_sensor` and shares the single doorway between two requesters, Bart and Homer. It grants the door to one requester at a time, releases the lock, and validates the G[1:0] beam pattern of the pass. On a valid pass it updates a per-person occupancy record; on a malformed pattern or a timeout it flags an error.

## Interface
- TIMEOUT, 50: max cycles from grant to completed pass before abort (≥4)
- CNT_W, 8: width of timeout counter; TIMEOUT must be < 2^CNT_W
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  2  door request; bit0 Bart, bit1 Homer; level, held until GRANT or withdrawn
- DIR  in  2  per-requester direction, sampled with REQ: 1 = enter, 0 = exit
- G  in  2  beam sensors; G[0] low beam, G[1] high beam
- GRANT  out  2  one-hot grant, registered; 00 when idle
- UNLOCK  out  1  door unlocked; equals |GRANT
- DONE  out  1  one-cycle pulse on valid pass completion
- ERR  out  1  one-cycle pulse on pattern error or timeout
- OCC  out  2  occupancy record: bit0 Bart inside, bit1 Homer inside
- LEVEL  out  2  number of persons inside (0..2) = OCC[0]+OCC[1]

## Operation
- Request masking: a request is eligible only when its direction is consistent with OCC (enter only if outside, exit only if inside). Ineligible requests are ignored and never granted.
- Arbitration: round-robin between eligible requests. The pointer points to the requester not granted last; after reset it favours Bart. A single eligible request is granted regardless of the pointer.
- The FSM latches the granted requester and its DIR at grant.
- IDLE: GRANT=00. If any eligible request is present and G==00, go to GRANTED. If G≠00 in IDLE, the grant is withheld; there is no error.
- GRANTED: GRANT set and the timeout counter cleared.
  - If the granted REQ bit drops while G==00, return to IDLE silently.
  - On the first G≠00, go to PASS.
- PASS, Bart grant: the only legal nonzero value is 01; any 10 or 11 → ABORT. G==00 after 01 → DONE.
- PASS, Homer grant: the first nonzero value must be 10, otherwise → ABORT. Then at least one 01 or 11 is required before G returns to 00. A return to 00 after only 10 → ABORT. Legal sequence → DONE. REQ changes are ignored in PASS.
- DONE (1 cycle): DONE=1. Toggle the granted person's OCC bit (set on enter, clear on exit). GRANT → 00. Update the round-robin pointer. Next state is IDLE.
- ABORT (1 cycle): ERR=1, OCC unchanged, GRANT → 00, pointer updated. Next state is IDLE.
- Timeout: if the counter reaches TIMEOUT in GRANTED or PASS → ABORT. This takes precedence over a same-cycle completion.

## Timing
- Reset (async assert, sync release): state IDLE, GRANT=00, UNLOCK=0, DONE=0, ERR=0, OCC=00, LEVEL=0, pointer=Bart, counter=0.
- REQ sampled at edge N → GRANT valid after edge N (1-cycle latency).
- G is sampled every edge. First G≠00 at edge M → state PASS after edge M.
- Final G==00 sampled at edge K → DONE high for exactly the cycle after edge K, with OCC/LEVEL updated in the same cycle. GRANT is 00 from that cycle on.
- Back-to-back: the earliest next GRANT is the cycle after DONE/ERR (a 1-cycle gap with UNLOCK=0).
- Counter increments once per cycle in GRANTED/PASS. ABORT fires in the cycle after the counter equals TIMEOUT.
- RESET_N asserted mid-pass: everything is cleared immediately and the partial pass is discarded without a DONE or ERR pulse.

## Test plan
- Bart enters: REQ=01, DIR=01, G: 00→01→00 → GRANT=01 one cycle after REQ; DONE pulse; OCC=01, LEVEL=1.
- Homer enters, then exits, both patterns: G 10→01→00 gives OCC=10. Exit with G 10→11→00 gives OCC=00. Two DONE pulses, no ERR.
- Contention: REQ=11 (both enter) from reset → Bart granted first. After DONE, Homer granted (round-robin). Final OCC=11, LEVEL=2.
- Pattern error: Homer granted, G 01→00 → ERR pulse, no DONE, OCC unchanged. Bart granted, G 10 → ERR.
- Timeout: TIMEOUT=10, grant Bart, hold G=00 with REQ held → ERR pulse the cycle after count reaches 10, GRANT=00.
- Masking and reset: REQ=01 with DIR=00 while OCC[0]=0 → no grant for 20 cycles. RESET_N=0 mid-PASS → all outputs zero, OCC=00.

Source files
------------

// File: rtl/simpsons_door_arbiter.sv
// Door-access arbiter: round-robin grants the doorway to Bart or Homer, checks the
// G[1:0] beam pattern of the pass and keeps a per-person occupancy record.
module simpsons_door_arbiter #(
  parameter int unsigned TIMEOUT = 50,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] REQ,
  input  logic [1:0] DIR,
  input  logic [1:0] G,
  output logic [1:0] GRANT,
  output logic       UNLOCK,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] OCC,
  output logic [1:0] LEVEL
);

  typedef enum logic [2:0] {StIdle, StGranted, StPass, StDone, StAbort} state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             who_q, who_d;     // 0 = Bart, 1 = Homer
  logic             dir_q, dir_d;     // 1 = enter, 0 = exit
  logic             ptr_q, ptr_d;     // requester favoured on a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bad_q, bad_d;     // first nonzero beam value was illegal
  logic             hit_q, hit_d;     // Homer pass has seen the low beam
  logic [1:0]       occ_q, occ_d;

  logic [1:0] elig;
  logic       pick;
  logic       timeout;
  logic       go_done;
  logic       go_abort;

  // Eligibility masking and tie-break selection
  always_comb begin
    elig    = REQ & (DIR ^ occ_q);  // enter only if outside, exit only if inside
    pick    = (elig == 2'b11) ? ptr_q : elig[1];
    timeout = (cnt_q == TimeoutCnt);
  end

  // Next-state logic for the door FSM and its bookkeeping
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    who_d    = who_q;
    dir_d    = dir_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    hit_d    = hit_q;
    occ_d    = occ_q;
    go_done  = 1'b0;
    go_abort = 1'b0;

    unique case (state_q)
      // DONE/ABORT re-arbitrate so the next grant can follow after a 1-cycle gap
      StIdle, StDone, StAbort: begin
        state_d = StIdle;
        grant_d = 2'b00;
        if ((|elig) && (G == 2'b00)) begin
          state_d = StGranted;
          who_d   = pick;
          dir_d   = DIR[pick];
          grant_d = pick ? 2'b10 : 2'b01;
          cnt_d   = '0;
        end
      end
      StGranted: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          go_abort = 1'b1;
        end else if (G == 2'b00) begin
          if (!REQ[who_q]) begin
            state_d = StIdle;
            grant_d = 2'b00;
          end
        end else begin
          state_d = StPass;
          hit_d   = 1'b0;
          bad_d   = who_q ? (G != 2'b10) : (G != 2'b01);
        end
      end
      StPass: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout || bad_q) begin
          go_abort = 1'b1;
        end else if (!who_q) begin
          if (G[1]) go_abort = 1'b1;
          else if (G == 2'b00) go_done = 1'b1;
        end else begin
          if (G == 2'b00) begin
            if (hit_q) go_done = 1'b1;
            else go_abort = 1'b1;
          end else if (G[0]) begin
            hit_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase

    if (go_done) begin
      state_d       = StDone;
      grant_d       = 2'b00;
      ptr_d         = ~who_q;
      occ_d[who_q]  = dir_q;
    end
    if (go_abort) begin
      state_d = StAbort;
      grant_d = 2'b00;
      ptr_d   = ~who_q;
    end
  end

  // State and record registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      who_q   <= 1'b0;
      dir_q   <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      hit_q   <= 1'b0;
      occ_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      who_q   <= who_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      hit_q   <= hit_d;
      occ_q   <= occ_d;
    end
  end

  // Output decode
  always_comb begin
    GRANT  = grant_q;
    UNLOCK = |grant_q;
    DONE   = (state_q == StDone);
    ERR    = (state_q == StAbort);
    OCC    = occ_q;
    LEVEL  = {1'b0, occ_q[0]} + {1'b0, occ_q[1]};
  end

endmodule

// File: tb/tb_simpsons_door_arbiter.sv
// Scoreboard bench for simpsons_door_arbiter: each pass pushes its expected outcome,
// a negedge monitor pops and compares when DONE or ERR fires.
module tb_simpsons_door_arbiter;

  localparam int unsigned TO = 10;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] REQ = 2'b00;
  logic [1:0] DIR = 2'b00;
  logic [1:0] G = 2'b00;
  logic [1:0] GRANT;
  logic       UNLOCK;
  logic       DONE;
  logic       ERR;
  logic [1:0] OCC;
  logic [1:0] LEVEL;

  simpsons_door_arbiter #(
    .TIMEOUT(TO),
    .CNT_W  (8)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .REQ    (REQ),
    .DIR    (DIR),
    .G      (G),
    .GRANT  (GRANT),
    .UNLOCK (UNLOCK),
    .DONE   (DONE),
    .ERR    (ERR),
    .OCC    (OCC),
    .LEVEL  (LEVEL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       err;
    logic [1:0] occ;
  } evt_t;

  evt_t       exp_q[$];
  logic [1:0] occ_m = 2'b00;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor
  always @(negedge CLK) begin
    if (RESET_N && (DONE || ERR)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", {30'd0, DONE, ERR}, 32'd0);
      end else begin
        evt_t ev;
        ev = exp_q.pop_front();
        chk("evt_kind", {30'd0, DONE, ERR}, ev.err ? 32'd1 : 32'd2);
        chk("evt_occ", {30'd0, OCC}, {30'd0, ev.occ});
        chk("evt_level", {30'd0, LEVEL}, 32'(ev.occ[0]) + 32'(ev.occ[1]));
        chk("evt_grant_off", {30'd0, GRANT}, 32'd0);
        chk("evt_unlock_off", {31'd0, UNLOCK}, 32'd0);
      end
    end
  end

  task automatic wait_evt();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      chk("evt_wait", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic do_pass(input int who, input logic dir, input logic [1:0] g0,
                         input logic [1:0] g1, input int n, input bit err);
    evt_t ev;
    if (!err) occ_m[who] = dir;
    ev.err = err;
    ev.occ = occ_m;
    exp_q.push_back(ev);
    REQ = 2'b00;
    REQ[who] = 1'b1;
    DIR = 2'b00;
    DIR[who] = dir;
    G = 2'b00;
    @(negedge CLK);
    chk("grant", {30'd0, GRANT}, (who == 1) ? 32'd2 : 32'd1);
    chk("unlock", {31'd0, UNLOCK}, 32'd1);
    G = g0;
    @(negedge CLK);
    REQ = 2'b00;
    if (n > 1) begin
      G = g1;
      @(negedge CLK);
    end
    G = 2'b00;
    wait_evt();
  endtask

  task automatic pulse_reset();
    RESET_N = 1'b0;
    REQ = 2'b00;
    G = 2'b00;
    exp_q.delete();
    occ_m = 2'b00;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_t ev;
    // Reset state
    @(negedge CLK);
    chk("rst_grant", {30'd0, GRANT}, 32'd0);
    chk("rst_flags", {29'd0, UNLOCK, DONE, ERR}, 32'd0);
    chk("rst_occ", {30'd0, OCC}, 32'd0);
    chk("rst_level", {30'd0, LEVEL}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Bart asking to exit while outside: never granted
    REQ = 2'b01;
    DIR = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("mask_grant", {30'd0, GRANT}, 32'd0);
    end
    REQ = 2'b00;
    @(negedge CLK);

    do_pass(0, 1'b1, 2'b01, 2'b00, 1, 1'b0);  // Bart enters
    do_pass(1, 1'b1, 2'b10, 2'b01, 2, 1'b0);  // Homer enters
    do_pass(1, 1'b0, 2'b10, 2'b11, 2, 1'b0);  // Homer exits
    do_pass(1, 1'b1, 2'b01, 2'b00, 1, 1'b1);  // Homer wrong first beam
    do_pass(0, 1'b0, 2'b10, 2'b00, 1, 1'b1);  // Bart high beam
    do_pass(1, 1'b1, 2'b10, 2'b00, 1, 1'b1);  // Homer high beam only

    // Timeout: Bart (inside) granted to exit, beams never broken
    ev.err = 1'b1;
    ev.occ = occ_m;
    exp_q.push_back(ev);
    REQ = 2'b01;
    DIR = 2'b00;
    G = 2'b00;
    @(negedge CLK);
    chk("to_grant", {30'd0, GRANT}, 32'd1);
    for (int i = 1; i <= int'(TO); i++) begin
      @(negedge CLK);
      chk("to_no_err", {31'd0, ERR}, 32'd0);
      chk("to_hold_grant", {30'd0, GRANT}, 32'd1);
    end
    @(negedge CLK);
    REQ = 2'b00;
    chk("to_err", {31'd0, ERR}, 32'd1);
    chk("to_grant_off", {30'd0, GRANT}, 32'd0);
    wait_evt();

    // Contention from reset: Bart first, then Homer right after the gap cycle
    pulse_reset();
    ev.err = 1'b0;
    ev.occ = 2'b01;
    exp_q.push_back(ev);
    ev.occ = 2'b11;
    exp_q.push_back(ev);
    occ_m = 2'b11;
    REQ = 2'b11;
    DIR = 2'b11;
    G = 2'b00;
    @(negedge CLK);
    chk("cont_first", {30'd0, GRANT}, 32'd1);
    G = 2'b01;
    @(negedge CLK);
    REQ = 2'b10;
    G = 2'b00;
    @(negedge CLK);
    chk("cont_done", {31'd0, DONE}, 32'd1);
    @(negedge CLK);
    chk("cont_second", {30'd0, GRANT}, 32'd2);
    G = 2'b10;
    @(negedge CLK);
    REQ = 2'b00;
    G = 2'b01;
    @(negedge CLK);
    G = 2'b00;
    wait_evt();
    chk("cont_level", {30'd0, LEVEL}, 32'd2);

    // Reset in the middle of a Homer exit pass
    REQ = 2'b10;
    DIR = 2'b00;
    @(negedge CLK);
    chk("mid_grant", {30'd0, GRANT}, 32'd2);
    G = 2'b10;
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_outs", {26'd0, GRANT, UNLOCK, DONE, ERR, LEVEL}, 32'd0);
    chk("mid_rst_occ", {30'd0, OCC}, 32'd0);
    occ_m = 2'b00;
    REQ = 2'b00;
    G = 2'b00;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_flags", {29'd0, UNLOCK, DONE, ERR}, 32'd0);
    do_pass(0, 1'b1, 2'b01, 2'b01, 2, 1'b0);  // recovery pass

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
